// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first parallel-to-serial transmitter with a saturating 011 counter
module serial_pattern_tx #(
    parameter int   WIDTH      = 8,
    parameter int   LEN_W      = 4,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic [LEN_W-1:0] LOAD_LEN,
    input  logic             START,
    output logic             READY,
    output logic             X,
    output logic             X_VALID,
    output logic             DONE,
    output logic [7:0]       PATTERN_COUNT,
    output logic [1:0]       CurrentState
);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_SHIFT = 2'b01, S_DONE = 2'b10, S_BAD = 2'b11} state_t;
    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       hist;
    logic [LEN_W-1:0] eff_len;
    assign CurrentState = state;
    // Requested lengths above WIDTH are clamped to a full word
    always_comb eff_len = (LOAD_LEN > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : LOAD_LEN;
    // Frame FSM; the first bit is driven at the capture edge, remaining counts bits still to send
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state         <= S_IDLE;
            shreg         <= '0;
            remaining     <= '0;
            hist          <= 2'b11;
            X             <= IDLE_LEVEL;
            X_VALID       <= 1'b0;
            DONE          <= 1'b0;
            READY         <= 1'b1;
            PATTERN_COUNT <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START && LOAD_LEN != '0) begin
                        state     <= S_SHIFT;
                        X         <= LOAD_DATA[WIDTH-1];
                        X_VALID   <= 1'b1;
                        READY     <= 1'b0;
                        shreg     <= LOAD_DATA << 1;
                        remaining <= eff_len - 1'b1;
                        hist      <= {1'b1, LOAD_DATA[WIDTH-1]};
                    end
                end
                S_SHIFT: begin
                    if (remaining == '0) begin
                        state   <= S_DONE;
                        X       <= IDLE_LEVEL;
                        X_VALID <= 1'b0;
                        DONE    <= 1'b1;
                    end else begin
                        X         <= shreg[WIDTH-1];
                        shreg     <= shreg << 1;
                        remaining <= remaining - 1'b1;
                        hist      <= {hist[0], shreg[WIDTH-1]};
                        if (hist == 2'b01 && shreg[WIDTH-1] && PATTERN_COUNT != 8'hFF)
                            PATTERN_COUNT <= PATTERN_COUNT + 8'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    X       <= IDLE_LEVEL;
                    X_VALID <= 1'b0;
                    DONE    <= 1'b0;
                    READY   <= 1'b1;
                end
            endcase
        end
    end
endmodule
